p_inv_seq: RTL and testbench

P_INV_SEQ -- requirements
Module: p_inv_seq

---
 rtl/p_inv_seq.sv | 146 ++++++++++++++
 tb/tb_p_inv_seq.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/p_inv_seq.sv
// Inverse of the 320-bit permutation, one inverse round per clock.
// Undoes forward rounds ROUND_LAST down to round_start_i. Each inverse round
// applies the inverse linear layer, then the inverse S-box, then removes the
// round constant.
module p_inv_seq #(
  parameter int unsigned ROUND_LAST = 11
) (
  input  logic             clock_i,
  input  logic             resetb_i,
  input  logic             start_i,
  input  logic [3:0]       round_start_i,
  input  logic [4:0][63:0] state_i,
  output logic [4:0][63:0] state_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam logic [3:0] RoundLast = 4'(ROUND_LAST);

  localparam logic [4:0] InvSbox [32] = '{
    5'd20, 5'd26, 5'd7,  5'd13, 5'd0,  5'd9,  5'd14, 5'd18,
    5'd10, 5'd6,  5'd29, 5'd1,  5'd25, 5'd21, 5'd19, 5'd30,
    5'd24, 5'd22, 5'd11, 5'd17, 5'd3,  5'd5,  5'd28, 5'd31,
    5'd23, 5'd27, 5'd4,  5'd8,  5'd15, 5'd12, 5'd16, 5'd2
  };

  typedef enum logic [1:0] {StIdle, StRun, StDone} fsm_e;

  fsm_e             fsm_q;
  logic [3:0]       cnt_q;
  logic [3:0]       round_first_q;
  logic [4:0][63:0] st_q;
  logic [4:0][63:0] st_round;
  logic             busy_q;
  logic             done_q;

  function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned r);
    logic [127:0] xx;
    xx = {x, x} >> r;
    return xx[63:0];
  endfunction

  // The forward map is multiplication by 1+u in GF(2)[z]/(z^64+1) with u^64 = 0,
  // so its inverse is (1+u)^63 = prod over k=0..5 of (1+u^(2^k)); squaring just
  // doubles the rotation amounts (mod 64).
  function automatic logic [63:0] sigma_inv(input logic [63:0] x, input int unsigned a,
                                            input int unsigned b);
    logic [63:0] y;
    int unsigned ra;
    int unsigned rb;
    y  = x;
    ra = a;
    rb = b;
    for (int k = 0; k < 6; k++) begin
      y  = y ^ ror64(y, ra) ^ ror64(y, rb);
      ra = (ra * 2) % 64;
      rb = (rb * 2) % 64;
    end
    return y;
  endfunction

  function automatic logic [4:0][63:0] inv_round(input logic [4:0][63:0] s,
                                                 input logic [3:0] i);
    logic [4:0][63:0] t;
    logic [4:0][63:0] u;
    logic [4:0]       v;
    logic [4:0]       o;
    t[0] = sigma_inv(s[0], 19, 28);
    t[1] = sigma_inv(s[1], 61, 39);
    t[2] = sigma_inv(s[2], 1, 6);
    t[3] = sigma_inv(s[3], 10, 17);
    t[4] = sigma_inv(s[4], 7, 41);
    u = '0;
    // Word 0 supplies the MSB of each 5-bit column.
    for (int k = 0; k < 64; k++) begin
      v = {t[0][k], t[1][k], t[2][k], t[3][k], t[4][k]};
      o = InvSbox[v];
      u[0][k] = o[4];
      u[1][k] = o[3];
      u[2][k] = o[2];
      u[3][k] = o[1];
      u[4][k] = o[0];
    end
    u[2][7:0] = u[2][7:0] ^ {~i, i};
    return u;
  endfunction

  // Inverse round for the current counter value.
  always_comb begin
    st_round = inv_round(st_q, cnt_q);
  end

  // Control FSM; state, counter and outputs all registered.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      fsm_q         <= StIdle;
      cnt_q         <= 4'd0;
      round_first_q <= 4'd0;
      st_q          <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      unique case (fsm_q)
        StIdle: begin
          if (start_i) begin
            st_q <= state_i;
            if (round_start_i > RoundLast) begin
              // Nothing to undo: report completion straight away.
              fsm_q  <= StDone;
              done_q <= 1'b1;
            end else begin
              cnt_q         <= RoundLast;
              round_first_q <= round_start_i;
              fsm_q         <= StRun;
              busy_q        <= 1'b1;
            end
          end
        end
        StRun: begin
          st_q <= st_round;
          if (cnt_q == round_first_q) begin
            fsm_q  <= StDone;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StDone: begin
          done_q <= 1'b0;
          fsm_q  <= StIdle;
        end
        default: begin
          fsm_q  <= StIdle;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign state_o = st_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_p_inv_seq.sv
// Bench for p_inv_seq: a forward-permutation model builds inputs, and an inverse
// model (inverse linear layer as 63 forward applications) predicts outputs.
module tb_p_inv_seq;

  typedef logic [4:0][63:0] st_t;

  localparam int RL = 11;
  localparam int RotA [5] = '{19, 61, 1, 10, 7};
  localparam int RotB [5] = '{28, 39, 6, 17, 41};
  localparam int InvTab [32] = '{20, 26, 7, 13, 0, 9, 14, 18, 10, 6, 29, 1, 25, 21, 19, 30,
                                 24, 22, 11, 17, 3, 5, 28, 31, 23, 27, 4, 8, 15, 12, 16, 2};

  logic       clock_i;
  logic       resetb_i;
  logic       start_i;
  logic [3:0] round_start_i;
  st_t        state_i;
  st_t        state_o;
  logic       busy_o;
  logic       done_o;

  int fwd_tab [32];
  int pass_n = 0;
  int chk_n  = 0;
  bit chk_en = 0;
  int done_pulses = 0;

  // Model state: RUN cycles left, pending done, predicted final state.
  int  m_left;
  bit  m_done;
  st_t m_final;

  p_inv_seq #(.ROUND_LAST(RL)) dut (
    .clock_i      (clock_i),
    .resetb_i     (resetb_i),
    .start_i      (start_i),
    .round_start_i(round_start_i),
    .state_i      (state_i),
    .state_o      (state_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  initial clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] exp);
    chk_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [63:0] ror(input logic [63:0] x, input int r);
    logic [127:0] t;
    t = {x, x};
    t = t >> r;
    return t[63:0];
  endfunction

  function automatic logic [63:0] lin_fwd(input logic [63:0] x, input int j);
    return x ^ ror(x, RotA[j]) ^ ror(x, RotB[j]);
  endfunction

  // The forward map has order dividing 64, so 63 applications give its inverse.
  function automatic logic [63:0] lin_inv(input logic [63:0] x, input int j);
    logic [63:0] y;
    y = x;
    repeat (63) y = lin_fwd(y, j);
    return y;
  endfunction

  function automatic logic [7:0] rc(input int i);
    logic [3:0] ii;
    ii = 4'(i);
    return {~ii, ii};
  endfunction

  function automatic st_t apply_box(input st_t s, input bit inv);
    st_t r;
    int  v;
    int  o;
    for (int k = 0; k < 64; k++) begin
      v = 16 * int'(s[0][k]) + 8 * int'(s[1][k]) + 4 * int'(s[2][k]) + 2 * int'(s[3][k])
          + int'(s[4][k]);
      o = inv ? InvTab[v] : fwd_tab[v];
      for (int j = 0; j < 5; j++) r[j][k] = o[4-j];
    end
    return r;
  endfunction

  function automatic st_t fwd_perm(input st_t s, input int rs);
    st_t t;
    t = s;
    for (int i = rs; i <= RL; i++) begin
      t[2][7:0] = t[2][7:0] ^ rc(i);
      t = apply_box(t, 1'b0);
      for (int j = 0; j < 5; j++) t[j] = lin_fwd(t[j], j);
    end
    return t;
  endfunction

  function automatic st_t inv_perm(input st_t s, input int rs);
    st_t t;
    t = s;
    for (int i = RL; i >= rs; i--) begin
      for (int j = 0; j < 5; j++) t[j] = lin_inv(t[j], j);
      t = apply_box(t, 1'b1);
      t[2][7:0] = t[2][7:0] ^ rc(i);
    end
    return t;
  endfunction

  function automatic st_t rnd_state();
    st_t s;
    for (int j = 0; j < 5; j++) s[j] = {$urandom, $urandom};
    return s;
  endfunction

  // Reference model: countdown of RUN cycles, then a one-cycle done.
  always @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      m_left  <= 0;
      m_done  <= 1'b0;
      m_final <= '0;
    end else if (m_left == 0 && !m_done && start_i) begin
      if (int'(round_start_i) <= RL) m_left <= RL - int'(round_start_i) + 1;
      else m_done <= 1'b1;
      m_final <= inv_perm(state_i, int'(round_start_i));
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) m_done <= 1'b1;
    end else begin
      m_done <= 1'b0;
    end
  end

  // Per-cycle comparison against the model, mid-cycle.
  always @(negedge clock_i) begin
    if (chk_en) begin
      chk("busy", 320'(busy_o), 320'(m_left > 0));
      chk("done", 320'(done_o), 320'(m_done));
      if (m_left == 0) chk("state", state_o, m_final);
    end
    if (done_o) done_pulses <= done_pulses + 1;
  end

  // Called just after a negedge; returns at the negedge of the done cycle.
  task automatic do_pass(input st_t s, input logic [3:0] rs, input int inj_c, input st_t inj_s,
                         output int busy_n, output int done_at);
    state_i       = s;
    round_start_i = rs;
    start_i       = 1'b1;
    @(posedge clock_i);
    #1;
    start_i       = 1'b0;
    state_i       = rnd_state();
    round_start_i = 4'($urandom);
    busy_n  = 0;
    done_at = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clock_i);
      start_i = (c == inj_c);
      if (c == inj_c) state_i = inj_s;
      if (busy_o) busy_n++;
      if (done_o) begin
        done_at = c;
        break;
      end
    end
    start_i = 1'b0;
  endtask

  st_t v0;
  st_t x;
  int  bn;
  int  da;
  int  snap;
  int  n;
  int  rs;
  int  inj;

  initial begin
    resetb_i      = 1'b0;
    start_i       = 1'b0;
    round_start_i = 4'd0;
    state_i       = '0;
    for (int v = 0; v < 32; v++) fwd_tab[InvTab[v]] = v;
    v0[0] = 64'h80400c0600000000;
    v0[1] = 64'h0001020304050607;
    v0[2] = 64'h08090a0b0c0d0e0f;
    v0[3] = 64'h0011223344556677;
    v0[4] = 64'h8899aabbccddeeff;

    // Hand-computed pins for the model itself.
    chk("model_rc0", 320'(rc(0)), 320'(8'hF0));
    chk("model_rc11", 320'(rc(11)), 320'(8'h4B));
    chk("model_lin0", 320'(lin_fwd(64'h1, 0)), 320'(64'h0000_2010_0000_0001));
    chk("model_sbox20", 320'(fwd_tab[20]), 320'(0));
    chk("model_sbox2", 320'(fwd_tab[2]), 320'(31));
    for (int j = 0; j < 5; j++) begin
      x[0] = {$urandom, $urandom};
      chk("model_lin_inv", 320'(lin_inv(lin_fwd(x[0], j), j)), 320'(x[0]));
    end
    chk("model_roundtrip", inv_perm(fwd_perm(v0, 0), 0), v0);

    // Reset state, no clock edge needed.
    #3;
    chk("reset_state", state_o, '0);
    chk("reset_busy", 320'(busy_o), 320'(0));
    chk("reset_done", 320'(done_o), 320'(0));

    // Start presented together with reset release: honoured on first edge.
    @(negedge clock_i);
    resetb_i = 1'b1;
    chk_en   = 1'b1;
    do_pass(fwd_perm(v0, 11), 4'd11, 0, v0, bn, da);
    chk("single_busy", 320'(bn), 320'(1));
    chk("single_done_at", 320'(da), 320'(2));
    chk("single_state", state_o, v0);

    @(negedge clock_i);
    do_pass(fwd_perm(v0, 0), 4'd0, 0, v0, bn, da);
    chk("p12_busy", 320'(bn), 320'(12));
    chk("p12_done_at", 320'(da), 320'(13));
    chk("p12_state", state_o, v0);

    @(negedge clock_i);
    do_pass(fwd_perm(v0, 6), 4'd6, 0, v0, bn, da);
    chk("p6_done_at", 320'(da), 320'(7));
    chk("p6_state", state_o, v0);
    // Restart in the cycle right after DONE.
    @(negedge clock_i);
    do_pass(fwd_perm(v0, 11), 4'd11, 0, v0, bn, da);
    chk("restart_done_at", 320'(da), 320'(2));
    chk("restart_state", state_o, v0);

    @(negedge clock_i);
    do_pass(v0, 4'd13, 0, v0, bn, da);
    chk("zero_done_at", 320'(da), 320'(1));
    chk("zero_busy", 320'(bn), 320'(0));
    chk("zero_state", state_o, v0);

    // Start pulsed mid-pass must be ignored.
    @(negedge clock_i);
    #1 snap = done_pulses;
    do_pass(fwd_perm(v0, 0), 4'd0, 5, rnd_state(), bn, da);
    chk("busy_start_done_at", 320'(da), 320'(13));
    chk("busy_start_state", state_o, v0);
    repeat (3) @(negedge clock_i);
    #1 chk("busy_start_pulses", 320'(done_pulses - snap), 320'(1));

    // Reset in cycle 4 of a p12 pass.
    @(negedge clock_i);
    state_i       = fwd_perm(v0, 0);
    round_start_i = 4'd0;
    start_i       = 1'b1;
    @(posedge clock_i);
    #1 start_i = 1'b0;
    repeat (4) @(negedge clock_i);
    chk("inflight_busy", 320'(busy_o), 320'(1));
    #1 snap = done_pulses;
    resetb_i = 1'b0;
    #1;
    chk("inflight_rst_state", state_o, '0);
    chk("inflight_rst_busy", 320'(busy_o), 320'(0));
    chk("inflight_rst_done", 320'(done_o), 320'(0));
    repeat (2) @(negedge clock_i);
    resetb_i = 1'b1;
    repeat (15) @(negedge clock_i);
    #1 chk("inflight_no_done", 320'(done_pulses - snap), 320'(0));
    @(negedge clock_i);
    do_pass(fwd_perm(v0, 0), 4'd0, 0, v0, bn, da);
    chk("after_rst_done_at", 320'(da), 320'(13));
    chk("after_rst_state", state_o, v0);

    // Randomized passes, including zero-round requests and mid-pass starts.
    for (int t = 0; t < 30; t++) begin
      repeat ($urandom_range(1, 3)) @(negedge clock_i);
      x   = rnd_state();
      rs  = $urandom_range(0, 15);
      n   = (rs <= RL) ? RL - rs + 1 : 0;
      inj = (n >= 2 && $urandom_range(0, 1) == 1) ? $urandom_range(1, n) : 0;
      do_pass((rs <= RL) ? fwd_perm(x, rs) : x, 4'(rs), inj, rnd_state(), bn, da);
      chk("rnd_busy", 320'(bn), 320'(n));
      chk("rnd_done_at", 320'(da), 320'(n + 1));
      chk("rnd_state", state_o, x);
    end

    repeat (2) @(negedge clock_i);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", pass_n, chk_n);
    $finish;
  end

endmodule
